// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks a contiguous ROM address range and streams the returned
// words in order through a credit-limited FIFO with a valid/ready handshake.
module rom_stream_reader #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 16,
  parameter int LEN_W      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              ickr,
  input  logic              irst,
  input  logic              istart,
  input  logic [ADDR_W-1:0] ibase,
  input  logic [LEN_W-1:0]  ilen,
  input  logic              iabort,
  output logic              obusy,
  output logic              odone,
  output logic              orom_ren,
  output logic [ADDR_W-1:0] orom_addr,
  input  logic [DATA_W-1:0] irom_dout,
  output logic              oval,
  input  logic              irdy,
  output logic [DATA_W-1:0] odata,
  output logic [ADDR_W-1:0] oaddr,
  output logic              olast
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int PEND_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, ABORT} state_t;

  state_t state_q, state_d;

  logic              done_d;
  logic              load;
  logic              issue;
  logic              flush;
  logic              credit_ok;
  logic              push;
  logic              pop;
  logic              abort_wait;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue_last;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  issue_cnt;
  logic [LEN_W-1:0]  deliv_cnt;
  logic [PEND_W-1:0] pending;

  logic              vld_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic              last_p0;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic              last_p1;

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  // Credit is counted without the current pop so irdy never reaches the issue logic.
  assign pending    = PEND_W'(count) + PEND_W'(vld_p1) + PEND_W'(vld_p0);
  assign credit_ok  = (pending < PEND_W'(FIFO_DEPTH));
  assign issue_addr = load ? ibase : ptr;
  assign issue_last = load ? (ilen == LEN_W'(1)) : (issue_cnt == LEN_W'(1));
  assign push       = vld_p1 & ~flush;
  assign pop        = oval & irdy & ~flush;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    load    = 1'b0;
    issue   = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (istart) begin
          if (ilen == '0) begin
            done_d = 1'b1;
          end else begin
            load    = 1'b1;
            issue   = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (iabort) begin
          flush   = 1'b1;
          state_d = ABORT;
        end else begin
          issue = credit_ok && (issue_cnt != '0);
          if ((issue_cnt == '0) || (issue && issue_cnt == LEN_W'(1))) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (iabort) begin
          flush   = 1'b1;
          state_d = ABORT;
        end else if (pop && deliv_cnt == LEN_W'(1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      ABORT: begin
        flush = 1'b1;
        if (abort_wait) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ickr) begin
    if (irst) begin
      state_q <= IDLE;
      odone   <= 1'b0;
    end else begin
      state_q <= state_d;
      odone   <= done_d;
    end
  end

  // Stage p0: read issued to the ROM; stage p1: ROM word returning on irom_dout.
  always_ff @(posedge ickr) begin
    if (irst) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      addr_p0    <= '0;
      ptr        <= '0;
      issue_cnt  <= '0;
      deliv_cnt  <= '0;
      abort_wait <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      vld_p0     <= issue;
      vld_p1     <= vld_p0 & ~flush;
      abort_wait <= (state_q == ABORT);
      if (issue) begin
        addr_p0   <= issue_addr;
        ptr       <= issue_addr + ADDR_W'(1);
        issue_cnt <= (load ? ilen : issue_cnt) - LEN_W'(1);
      end
      if (load)     deliv_cnt <= ilen;
      else if (pop) deliv_cnt <= deliv_cnt - LEN_W'(1);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ickr) begin
    if (issue) last_p0 <= issue_last;
    addr_p1 <= addr_p0;
    last_p1 <= last_p0;
    if (push) begin
      fifo_data[wr_ptr] <= irom_dout;
      fifo_addr[wr_ptr] <= addr_p1;
      fifo_last[wr_ptr] <= last_p1;
    end
  end

  assign obusy     = (state_q != IDLE);
  assign orom_ren  = vld_p0;
  assign orom_addr = addr_p0;
  assign oval      = (count != '0);
  assign odata     = oval ? fifo_data[rd_ptr] : '0;
  assign oaddr     = oval ? fifo_addr[rd_ptr] : '0;
  assign olast     = oval & fifo_last[rd_ptr];

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: ROM model, directed transfers, and a scoreboard
// monitor that checks every handshaken word against the queued expectation.
module tb_rom_stream_reader;

  logic        ickr;
  logic        irst;
  logic        istart;
  logic [10:0] ibase;
  logic [11:0] ilen;
  logic        iabort;
  logic        obusy;
  logic        odone;
  logic        orom_ren;
  logic [10:0] orom_addr;
  logic [15:0] rom_dout = '0;
  logic        oval;
  logic        irdy;
  logic [15:0] odata;
  logic [10:0] oaddr;
  logic        olast;

  typedef struct packed {
    logic [15:0] data;
    logic [10:0] addr;
    logic        last;
  } exp_t;

  exp_t exp_q[$];

  int checks    = 0;
  int failures  = 0;
  int ren_x     = 0;
  int hs_x      = 0;
  int oval_x    = 0;
  int done_cnt  = 0;
  int max_out   = 0;
  int cyc       = 0;
  int first_cyc = 0;
  int last_cyc  = 0;
  int d0;
  logic rnd_mode  = 1'b0;
  logic rdy_level = 1'b1;

  rom_stream_reader dut (
    .ickr      (ickr),
    .irst      (irst),
    .istart    (istart),
    .ibase     (ibase),
    .ilen      (ilen),
    .iabort    (iabort),
    .obusy     (obusy),
    .odone     (odone),
    .orom_ren  (orom_ren),
    .orom_addr (orom_addr),
    .irom_dout (rom_dout),
    .oval      (oval),
    .irdy      (irdy),
    .odata     (odata),
    .oaddr     (oaddr),
    .olast     (olast)
  );

  initial begin
    ickr = 1'b0;
    forever #5 ickr = ~ickr;
  end

  // Registered ROM: word for an address read in cycle c is on rom_dout during c+1.
  always @(posedge ickr) begin
    if (orom_ren) rom_dout <= {5'b0, orom_addr} ^ 16'hA5A5;
  end

  initial begin
    irdy = 1'b1;
    forever begin
      @(posedge ickr);
      #1;
      irdy = rnd_mode ? ($urandom_range(0, 99) >= 30) : rdy_level;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge ickr) begin
    exp_t e;
    int   outstanding;
    cyc++;
    if (!irst) begin
      if (orom_ren) ren_x++;
      if (oval) oval_x++;
      if (odone) done_cnt++;
      outstanding = ren_x - hs_x;
      if (outstanding > max_out) max_out = outstanding;
      if (oval && irdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=addr %0d required=no word", oaddr);
        end else begin
          e = exp_q.pop_front();
          check("word_data", 32'(odata), 32'(e.data));
          check("word_addr", 32'(oaddr), 32'(e.addr));
          check("word_last", 32'(olast), 32'(e.last));
        end
        if (hs_x == 0) first_cyc = cyc;
        last_cyc = cyc;
        hs_x++;
      end
    end
  end

  task automatic start(input logic [10:0] b, input logic [11:0] l);
    exp_t        e;
    logic [10:0] a;
    for (int i = 0; i < int'(l); i++) begin
      a      = b + 11'(i);
      e.data = {5'b0, a} ^ 16'hA5A5;
      e.addr = a;
      e.last = (i == int'(l) - 1);
      exp_q.push_back(e);
    end
    ren_x  = 0;
    hs_x   = 0;
    oval_x = 0;
    ibase  = b;
    ilen   = l;
    istart = 1'b1;
    @(posedge ickr);
    #1;
    istart = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (odone !== 1'b1 && n < budget) begin
      @(posedge ickr);
      #1;
      n++;
    end
    check("done_seen", 32'(odone), 32'd1);
    check("busy_low_at_done", 32'(obusy), 32'd0);
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n;
    n = 0;
    while (hs_x < target && n < budget) begin
      @(posedge ickr);
      #1;
      n++;
    end
    check("hs_reached", 32'(hs_x >= target), 32'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", 32'(obusy), 32'd0);
    check("rst_done", 32'(odone), 32'd0);
    check("rst_ren", 32'(orom_ren), 32'd0);
    check("rst_rom_addr", 32'(orom_addr), 32'd0);
    check("rst_val", 32'(oval), 32'd0);
    check("rst_data", 32'(odata), 32'd0);
    check("rst_addr", 32'(oaddr), 32'd0);
    check("rst_last", 32'(olast), 32'd0);
  endtask

  initial begin
    irst   = 1'b1;
    istart = 1'b0;
    ibase  = '0;
    ilen   = '0;
    iabort = 1'b0;
    repeat (3) @(posedge ickr);
    #1;
    check_reset_outputs();
    irst = 1'b0;
    @(posedge ickr);
    #1;

    // Single word at address 10, cycle-exact latency
    start(11'd10, 12'd1);
    check("t1_ren_k1", 32'(orom_ren), 32'd1);
    check("t1_rom_addr", 32'(orom_addr), 32'd10);
    check("t1_val_k1", 32'(oval), 32'd0);
    check("t1_busy", 32'(obusy), 32'd1);
    @(posedge ickr); #1;
    check("t1_ren_k2", 32'(orom_ren), 32'd0);
    check("t1_val_k2", 32'(oval), 32'd0);
    @(posedge ickr); #1;
    check("t1_val_k3", 32'(oval), 32'd1);
    check("t1_data", 32'(odata), 32'hA5AF);
    check("t1_last", 32'(olast), 32'd1);
    @(posedge ickr); #1;
    check("t1_done_k4", 32'(odone), 32'd1);
    check("t1_busy_k4", 32'(obusy), 32'd0);
    @(posedge ickr); #1;
    check("t1_done_pulse", 32'(odone), 32'd0);
    check("t1_ren_pulses", 32'(ren_x), 32'd1);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Wrap 2040..2047,0..7 back-to-back
    start(11'd2040, 12'd16);
    wait_done(100);
    check("t2_words", 32'(hs_x), 32'd16);
    check("t2_no_bubbles", 32'(last_cyc - first_cyc), 32'd15);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge ickr); #1;

    // Full ROM sweep under random backpressure
    max_out  = 0;
    rnd_mode = 1'b1;
    start(11'd0, 12'd2048);
    wait_done(20000);
    rnd_mode = 1'b0;
    check("t3_words", 32'(hs_x), 32'd2048);
    check("t3_max_outstanding_le4", 32'(max_out <= 4), 32'd1);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge ickr);
    #1;

    // Zero-length transfer
    start(11'd33, 12'd0);
    check("t4_done_k1", 32'(odone), 32'd1);
    check("t4_busy", 32'(obusy), 32'd0);
    repeat (3) @(posedge ickr);
    #1;
    check("t4_done_pulse", 32'(odone), 32'd0);
    check("t4_no_ren", 32'(ren_x), 32'd0);
    check("t4_no_val", 32'(oval_x), 32'd0);

    // Abort after 20 words, then a short transfer
    d0 = done_cnt;
    start(11'd0, 12'd100);
    wait_hs(20, 200);
    iabort = 1'b1;
    @(posedge ickr); #1;
    iabort = 1'b0;
    exp_q.delete();
    check("t5_val_flushed", 32'(oval), 32'd0);
    check("t5_busy_abort1", 32'(obusy), 32'd1);
    @(posedge ickr); #1;
    check("t5_busy_abort2", 32'(obusy), 32'd1);
    @(posedge ickr); #1;
    check("t5_idle_after_abort", 32'(obusy), 32'd0);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    start(11'd5, 12'd2);
    wait_done(50);
    check("t5_words_after", 32'(hs_x), 32'd2);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge ickr); #1;

    // istart during RUN must be ignored
    start(11'd100, 12'd8);
    @(posedge ickr); #1;
    ibase  = 11'd500;
    ilen   = 12'd3;
    istart = 1'b1;
    @(posedge ickr); #1;
    istart = 1'b0;
    wait_done(100);
    repeat (4) @(posedge ickr);
    #1;
    check("t6_words", 32'(hs_x), 32'd8);
    check("t6_idle", 32'(obusy), 32'd0);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-transfer, then a nominal transfer
    start(11'd300, 12'd50);
    wait_hs(5, 100);
    irst = 1'b1;
    @(posedge ickr); #1;
    irst = 1'b0;
    exp_q.delete();
    check_reset_outputs();
    oval_x = 0;
    d0     = done_cnt;
    repeat (4) @(posedge ickr);
    #1;
    check("t7_quiet_val", 32'(oval_x), 32'd0);
    check("t7_quiet_done", 32'(done_cnt - d0), 32'd0);
    start(11'd7, 12'd3);
    wait_done(50);
    check("t7_words", 32'(hs_x), 32'd3);
    check("t7_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
